// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage data-memory access controller (req/gnt/rvalid bus)
//
// Drives a variable-latency data bus for RV32I loads and stores and stalls the
// pipeline until the access finishes. The raw word-aligned read word is
// delivered on dram_data_mem_o; byte/half extraction happens downstream.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   instr_valid_mem_i   MEM-stage instruction valid
//   sl_type_mem_i       access type (LB/LH/LW/LBU/LHU/SB/SH/SW, else none)
//   alu_result_mem_i    effective byte address
//   store_data_mem_i    rs2 store data
//   dbus_req_o          bus request (registered)
//   dbus_we_o           write enable
//   dbus_addr_o         word address
//   dbus_wdata_o        lane-replicated write data
//   dbus_be_o           byte enables
//   dbus_gnt_i          request accepted
//   dbus_rvalid_i       read data valid
//   dbus_rdata_i        read data
//   mem_stall_o         hold IF..MEM, bubble into MEM/WB
//   dram_data_mem_o     captured read word
//   misalign_o          misaligned access flag
//   bus_err_o           timeout pulse

module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid_mem_i,
  input  logic [3:0]  sl_type_mem_i,
  input  logic [31:0] alu_result_mem_i,
  input  logic [31:0] store_data_mem_i,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [31:0] dbus_wdata_o,
  output logic [3:0]  dbus_be_o,
  input  logic        dbus_gnt_i,
  input  logic        dbus_rvalid_i,
  input  logic [31:0] dbus_rdata_i,
  output logic        mem_stall_o,
  output logic [31:0] dram_data_mem_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] to_cnt;

  logic        is_load;
  logic        is_store;
  logic        is_half;
  logic        is_word;
  logic        misaligned;
  logic        mem_op;
  logic        aligned_op;
  logic        timeout_hit;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;

  // Access-type decode; unlisted encodings fall through as "no access".
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    case (sl_type_mem_i)
      4'b0001, 4'b0100: is_load = 1'b1;
      4'b0010, 4'b0101: begin is_load = 1'b1;  is_half = 1'b1; end
      4'b0011:          begin is_load = 1'b1;  is_word = 1'b1; end
      4'b1001:          is_store = 1'b1;
      4'b1010:          begin is_store = 1'b1; is_half = 1'b1; end
      4'b1011:          begin is_store = 1'b1; is_word = 1'b1; end
      default: ;
    endcase
  end

  assign misaligned = (is_half && alu_result_mem_i[0]) ||
                      (is_word && (alu_result_mem_i[1:0] != 2'b00));
  assign mem_op     = instr_valid_mem_i && (is_load || is_store);
  assign aligned_op = mem_op && !misaligned;

  // Store data is replicated across lanes so the slave can pick any lane
  // selected by the byte enables without a shifter.
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = 32'h0;
    if (is_store) begin
      if (is_word) begin
        be_next    = 4'b1111;
        wdata_next = store_data_mem_i;
      end else if (is_half) begin
        be_next    = alu_result_mem_i[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{store_data_mem_i[15:0]}};
      end else begin
        be_next    = 4'b0001 << alu_result_mem_i[1:0];
        wdata_next = {4{store_data_mem_i[7:0]}};
      end
    end
  end

  assign timeout_hit = (to_cnt == CW'(TIMEOUT_CYCLES - 1));

  // The IDLE-cycle stall must be combinational so the pipeline freezes on the
  // very edge that launches the request. Gated by rst_n so reset forces it low.
  assign mem_stall_o = rst_n && (((state == S_IDLE) && aligned_op) ||
                                 (state == S_REQ) || (state == S_RESP));
  assign misalign_o  = rst_n && (state == S_IDLE) && mem_op && misaligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      to_cnt          <= '0;
      dbus_req_o      <= 1'b0;
      dbus_we_o       <= 1'b0;
      dbus_addr_o     <= 32'h0;
      dbus_wdata_o    <= 32'h0;
      dbus_be_o       <= 4'b0000;
      dram_data_mem_o <= 32'h0;
      bus_err_o       <= 1'b0;
    end else begin
      bus_err_o <= 1'b0;
      case (state)
        S_IDLE: begin
          to_cnt <= '0;
          if (aligned_op) begin
            dbus_addr_o  <= {alu_result_mem_i[31:2], 2'b00};
            dbus_we_o    <= is_store;
            dbus_be_o    <= be_next;
            dbus_wdata_o <= wdata_next;
            dbus_req_o   <= 1'b1;
            state        <= S_REQ;
          end
        end

        S_REQ: begin
          to_cnt <= to_cnt + CW'(1);
          if (dbus_gnt_i && (dbus_we_o || dbus_rvalid_i)) begin
            // Store accepted, or load answered in the grant cycle.
            dbus_req_o <= 1'b0;
            if (!dbus_we_o) dram_data_mem_o <= dbus_rdata_i;
            state <= S_DONE;
          end else if (timeout_hit) begin
            dbus_req_o      <= 1'b0;
            dram_data_mem_o <= 32'h0;
            bus_err_o       <= 1'b1;
            state           <= S_DONE;
          end else if (dbus_gnt_i) begin
            dbus_req_o <= 1'b0;
            state      <= S_RESP;
          end
        end

        S_RESP: begin
          to_cnt <= to_cnt + CW'(1);
          if (dbus_rvalid_i) begin
            dram_data_mem_o <= dbus_rdata_i;
            state           <= S_DONE;
          end else if (timeout_hit) begin
            dram_data_mem_o <= 32'h0;
            bus_err_o       <= 1'b1;
            state           <= S_DONE;
          end
        end

        S_DONE: begin
          // Pipeline advances on this edge; the next instruction is looked at
          // only once back in IDLE.
          to_cnt <= '0;
          state  <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - randomized self-checking bench for mem_access_ctrl

module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid_mem_i = 1'b0;
  logic [3:0]  sl_type_mem_i = 4'h0;
  logic [31:0] alu_result_mem_i = 32'h0;
  logic [31:0] store_data_mem_i = 32'h0;
  logic        dbus_req_o;
  logic        dbus_we_o;
  logic [31:0] dbus_addr_o;
  logic [31:0] dbus_wdata_o;
  logic [3:0]  dbus_be_o;
  logic        dbus_gnt_i = 1'b0;
  logic        dbus_rvalid_i = 1'b0;
  logic [31:0] dbus_rdata_i = 32'h0;
  logic        mem_stall_o;
  logic [31:0] dram_data_mem_o;
  logic        misalign_o;
  logic        bus_err_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_data = 32'h0;

  localparam int TMO = 16;

  mem_access_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid_mem_i(instr_valid_mem_i), .sl_type_mem_i(sl_type_mem_i),
    .alu_result_mem_i(alu_result_mem_i), .store_data_mem_i(store_data_mem_i),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_wdata_o(dbus_wdata_o), .dbus_be_o(dbus_be_o),
    .dbus_gnt_i(dbus_gnt_i), .dbus_rvalid_i(dbus_rvalid_i), .dbus_rdata_i(dbus_rdata_i),
    .mem_stall_o(mem_stall_o), .dram_data_mem_o(dram_data_mem_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit t_load(input logic [3:0] t);
    return (t == 4'd1) || (t == 4'd2) || (t == 4'd3) || (t == 4'd4) || (t == 4'd5);
  endfunction

  function automatic bit t_store(input logic [3:0] t);
    return (t == 4'd9) || (t == 4'd10) || (t == 4'd11);
  endfunction

  // Access size in bytes.
  function automatic int t_size(input logic [3:0] t);
    case (t)
      4'd1, 4'd4, 4'd9:  return 1;
      4'd2, 4'd5, 4'd10: return 2;
      default:           return 4;
    endcase
  endfunction

  // One instruction presented in IDLE; g = REQ cycles before gnt, r = cycles
  // from gnt to rvalid (0 = same cycle). Expectations come from the access
  // rules: lanes covered by the access, replicated data, latency sums, timeout.
  task automatic run_txn(input bit v, input logic [3:0] t, input logic [31:0] a,
                         input logic [31:0] d, input int g, input int r);
    bit          ld, st, mem, mis, e_to, done;
    int          sz, off, done_idx, e_stall, e_req, n_stall, n_req, n_err;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_addr, e_data, rv;
    ld  = v && t_load(t);
    st  = v && t_store(t);
    mem = ld || st;
    sz  = t_size(t);
    off = int'(a % 4);
    mis = mem && ((a % sz) != 0);
    e_addr = a - (a % 4);
    e_be = 4'b0000;
    e_wd = 32'h0;
    for (int k = 0; k < 4; k++) begin
      if (ld || (k >= off && k < off + sz)) e_be[k] = 1'b1;
      if (st) e_wd[8*k +: 8] = d[8*(k % sz) +: 8];
    end
    rv = $urandom;
    done_idx = st ? g : g + r;
    e_to     = done_idx > TMO - 1;
    e_stall  = 1 + (e_to ? TMO : done_idx + 1);
    e_req    = (g + 1 > TMO) ? TMO : g + 1;
    e_data   = e_to ? 32'h0 : (ld ? rv : last_data);
    n_stall = 0; n_req = 0; n_err = 0; done = 0;

    @(negedge clk);
    instr_valid_mem_i = v; sl_type_mem_i = t; alu_result_mem_i = a; store_data_mem_i = d;
    dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0;
    #1;
    check("misalign", {31'h0, misalign_o}, {31'h0, mis});
    if (!mem || mis) begin
      check("no_stall", {31'h0, mem_stall_o}, 32'h0);
      @(negedge clk);
      #1;
      check("no_req", {31'h0, dbus_req_o}, 32'h0);
      check("no_stall2", {31'h0, mem_stall_o}, 32'h0);
      check("data_hold", dram_data_mem_o, last_data);
      instr_valid_mem_i = 1'b0;
    end else begin
      for (int c = 0; c <= 40 && !done; c++) begin
        if (c > 0) #1;
        if (c > 0 && !mem_stall_o) begin
          check("bus_err", {31'h0, bus_err_o}, {31'h0, e_to});
          check("rd_data", dram_data_mem_o, e_data);
          check("stall_cycles", n_stall, e_stall);
          check("req_cycles", n_req, e_req);
          check("err_early", n_err, 0);
          check("req_done", {31'h0, dbus_req_o}, 32'h0);
          instr_valid_mem_i = 1'b0;
          dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0;
          last_data = e_data;
          done = 1;
        end else begin
          if (mem_stall_o) n_stall++;
          if (dbus_req_o) n_req++;
          if (bus_err_o) n_err++;
          if (c == 1) begin
            check("req_first", {31'h0, dbus_req_o}, 32'h1);
            check("addr", dbus_addr_o, e_addr);
            check("we", {31'h0, dbus_we_o}, {31'h0, st});
            check("be", {28'h0, dbus_be_o}, {28'h0, e_be});
            check("wdata", dbus_wdata_o, e_wd);
          end
          if (c >= 1) begin
            dbus_gnt_i    = (c - 1 == g);
            dbus_rvalid_i = ld && (c - 1 == g + r);
            dbus_rdata_i  = dbus_rvalid_i ? rv : $urandom;
          end
          @(negedge clk);
        end
      end
      if (!done) begin
        check("txn_bound", 32'h0, 32'h1);
        instr_valid_mem_i = 1'b0; dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0;
        rst_n = 1'b0; #1 rst_n = 1'b1;
        last_data = 32'h0;
      end
    end
  endtask

  // Reset asserted while a load waits in RESP; a late rvalid must be ignored.
  task automatic reset_mid_resp();
    @(negedge clk);
    instr_valid_mem_i = 1'b1; sl_type_mem_i = 4'b0011; alu_result_mem_i = 32'h100;
    dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0;
    @(negedge clk);
    #1 dbus_gnt_i = 1'b1;
    @(negedge clk);
    #1 dbus_gnt_i = 1'b0;
    check("rst_pre_stall", {31'h0, mem_stall_o}, 32'h1);
    rst_n = 1'b0; instr_valid_mem_i = 1'b0;
    #1;
    check("rst_req", {31'h0, dbus_req_o}, 32'h0);
    check("rst_stall", {31'h0, mem_stall_o}, 32'h0);
    check("rst_data", dram_data_mem_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'h5A5A_1234;
    @(negedge clk);
    dbus_rvalid_i = 1'b0;
    #1;
    check("late_rvalid_stall", {31'h0, mem_stall_o}, 32'h0);
    check("late_rvalid_req", {31'h0, dbus_req_o}, 32'h0);
    check("late_rvalid_data", dram_data_mem_o, 32'h0);
    last_data = 32'h0;
  endtask

  logic [3:0] types [11] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9, 4'd10, 4'd11, 4'd7, 4'd15};

  initial begin
    #3;
    check("reset_req", {31'h0, dbus_req_o}, 32'h0);
    check("reset_stall", {31'h0, mem_stall_o}, 32'h0);
    check("reset_data", dram_data_mem_o, 32'h0);
    check("reset_err", {31'h0, bus_err_o}, 32'h0);
    check("reset_be", {28'h0, dbus_be_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_txn(1, 4'b1011, 32'h0000_1004, 32'hDEAD_BEEF, 0, 0);
    run_txn(1, 4'b1001, 32'h0000_2003, 32'h0000_00A5, 0, 0);
    run_txn(1, 4'b1010, 32'h0000_2002, 32'h0000_1234, 0, 0);
    run_txn(1, 4'b0011, 32'h0000_0100, 32'h0, 2, 1);
    run_txn(1, 4'b0010, 32'h0000_0101, 32'h0, 0, 0);
    run_txn(1, 4'b0011, 32'h0000_0200, 32'h0, 0, 100);
    run_txn(1, 4'b0011, 32'h0000_0204, 32'h0, 0, 15);
    run_txn(1, 4'b1011, 32'h0000_0300, 32'h1111_2222, 15, 0);
    run_txn(1, 4'b1011, 32'h0000_0304, 32'h3333_4444, 16, 0);
    run_txn(1, 4'b0001, 32'h0000_0402, 32'h0, 0, 0);
    reset_mid_resp();

    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      int g, r;
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      g = ($urandom_range(0, 9) == 0) ? $urandom_range(12, 18) : $urandom_range(0, 3);
      r = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 3);
      run_txn($urandom_range(0, 7) != 0, types[$urandom_range(0, 10)], a, $urandom, g, r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- MEM-stage data-memory access controller for the 5-stage RV32I pipeline.
- Sits between the EX/MEM pipeline register and the MEM/WB pipeline register. Drives a variable-latency data bus with a req/gnt/rvalid handshake and stalls the pipeline until the access completes.
- Delivers the raw, word-aligned read word on dram_data_mem_o to the MEM/WB register. Byte/half extraction and sign-extension remain in the WB-stage LoadStoreUnit.

Parameters:
TIMEOUT_CYCLES, 16, cycles spent in REQ+RESP before the access is aborted with bus_err_o.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
instr_valid_mem_i  input  1  MEM-stage instruction valid
sl_type_mem_i  input  4  access type: 0000 none, 0001 LB, 0010 LH, 0011 LW, 0100 LBU, 0101 LHU, 1001 SB, 1010 SH, 1011 SW; others are treated as none
alu_result_mem_i  input  32  effective byte address
store_data_mem_i  input  32  rs2 store data
dbus_req_o  output  1  bus request
dbus_we_o  output  1  1 = write
dbus_addr_o  output  32  word address {addr[31:2],2'b00}
dbus_wdata_o  output  32  lane-replicated write data
dbus_be_o  output  4  byte enables
dbus_gnt_i  input  1  request accepted
dbus_rvalid_i  input  1  read data valid
dbus_rdata_i  input  32  read data
mem_stall_o  output  1  hold IF..MEM, insert bubble into MEM/WB
dram_data_mem_o  output  32  captured read word, to MEM/WB
misalign_o  output  1  misaligned access, 1-cycle flag
bus_err_o  output  1  timeout, 1-cycle pulse

Behaviour:
- Reset (async, rst_n=0): state=IDLE, all outputs 0, timeout counter 0. Reset during any state drops dbus_req_o immediately. Any late gnt/rvalid after reset is ignored.
- Memory op: instr_valid_mem_i=1 and sl_type_mem_i is a legal load or store.
- Misaligned condition: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=00. Misaligned ops issue no bus request, raise misalign_o combinationally in IDLE, and do not stall.
- State IDLE:
  - Aligned memory op: mem_stall_o=1 (combinational); register addr, we, be, wdata; go to REQ.
  - Otherwise stay in IDLE with mem_stall_o=0.
- State REQ:
  - dbus_req_o=1 (registered). addr, we, be and wdata are held stable until gnt.
  - gnt with store: go to DONE.
  - gnt with load and rvalid in the same cycle: capture rdata, go to DONE.
  - gnt with load, no rvalid: go to RESP.
  - mem_stall_o=1.
- State RESP:
  - dbus_req_o=0, mem_stall_o=1.
  - On rvalid: dram_data_mem_o <= dbus_rdata_i, go to DONE.
- State DONE:
  - mem_stall_o=0 for exactly one cycle, so the pipeline advances on this edge and MEM/WB captures dram_data_mem_o.
  - Go to IDLE. Do not re-examine inputs in this cycle; the next instruction is evaluated in IDLE.
- Timeout:
  - Counter increments each cycle in REQ or RESP and clears on entering IDLE.
  - When the count reaches TIMEOUT_CYCLES-1 without completion: drop req, set dram_data_mem_o=0, pulse bus_err_o for one cycle, go to DONE.
- Byte enables and write data:
  - SB: be = 0001 << addr[1:0], wdata = {4{d[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011, wdata = {2{d[15:0]}}.
  - SW: be = 1111, wdata = d.
  - Loads: be = 1111, we = 0, wdata = 0.
- dram_data_mem_o holds its last value until the next load capture, timeout, or reset.
- Minimum stall counts: store 2 cycles (IDLE, REQ with immediate gnt); load 2 cycles with same-cycle gnt+rvalid, 3 cycles with rvalid one cycle after gnt.

Test Plan:
- Reset mid-RESP → next cycle state IDLE; dbus_req_o=0, mem_stall_o=0, dram_data_mem_o=0. An rvalid arriving after reset is ignored.
- SW addr 0x0000_1004, data 0xDEADBEEF, gnt on first REQ cycle → addr 0x0000_1004, be 1111, wdata 0xDEADBEEF, we=1; stall high exactly 2 cycles.
- SB addr 0x0000_2003, data 0x0000_00A5 → addr 0x0000_2000, be 1000, wdata 0xA5A5A5A5. SH addr 0x0000_2002, data 0x1234 → be 1100, wdata 0x12341234.
- LW addr 0x100, gnt delayed 2 cycles, rvalid 1 cycle after gnt with 0xCAFEF00D → req held steady for 3 cycles; dram_data_mem_o=0xCAFEF00D in DONE; stall high 5 cycles.
- LH addr 0x0000_0101 → misalign_o=1 for 1 cycle, no dbus_req_o, mem_stall_o=0.
- LW with gnt but no rvalid, TIMEOUT_CYCLES=16 → bus_err_o pulses after 16 REQ+RESP cycles; dram_data_mem_o=0; FSM returns to IDLE.
